// File: rtl/apb_cfg_responder.sv
// APB3 completer for the accelerator configuration space.
// A zero-wait-state responder decodes transfers into a small register file.
// That register file drives start/enables, the BRAM base addresses and the
// validity mask, and records done_tpu as sticky status.
// Optional feature macro: APB_PSLVERR_EN adds the PSLVERR output. PSLVERR
// flags accesses to unmapped offsets and writes to ID.
module apb_cfg_responder #(
  parameter int REG_ADDRWIDTH = 8,
  parameter int REG_DATAWIDTH = 32,
  parameter int AWIDTH        = 10,
  parameter int MASK_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic [REG_ADDRWIDTH-1:0] PADDR,
  input  logic                     PWRITE,
  input  logic                     PSEL,
  input  logic                     PENABLE,
  input  logic [REG_DATAWIDTH-1:0] PWDATA,
  output logic [REG_DATAWIDTH-1:0] PRDATA,
  output logic                     PREADY,
`ifdef APB_PSLVERR_EN
  output logic                     PSLVERR,
`endif
  input  logic                     done_tpu,
  output logic                     start_tpu,
  output logic                     enable_matmul,
  output logic                     enable_norm,
  output logic                     enable_pool,
  output logic                     enable_activation,
  output logic [AWIDTH-1:0]        address_mat_a,
  output logic [AWIDTH-1:0]        address_mat_b,
  output logic [AWIDTH-1:0]        address_mat_c,
  output logic [MASK_WIDTH-1:0]    validity_mask
);

  localparam int IDX_W = REG_ADDRWIDTH - 2;

  // Word indices: the byte offset shifted right by two.
  localparam logic [IDX_W-1:0] IDX_CTRL   = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_STATUS = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ADDR_A = IDX_W'(2);
  localparam logic [IDX_W-1:0] IDX_ADDR_B = IDX_W'(3);
  localparam logic [IDX_W-1:0] IDX_ADDR_C = IDX_W'(4);
  localparam logic [IDX_W-1:0] IDX_MASK   = IDX_W'(5);
  localparam logic [IDX_W-1:0] IDX_ID     = IDX_W'(6);

  localparam logic [REG_DATAWIDTH-1:0] ID_VALUE = REG_DATAWIDTH'(32'h5450_5501);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t                  state;
  logic [IDX_W-1:0]        idx_lat;
  logic                    write_lat;

  logic [4:0]              ctrl_q;
  logic                    done_sticky;
  logic [AWIDTH-1:0]       addr_a_q;
  logic [AWIDTH-1:0]       addr_b_q;
  logic [AWIDTH-1:0]       addr_c_q;
  logic [MASK_WIDTH-1:0]   mask_q;

  logic [IDX_W-1:0]        setup_idx;
  logic [REG_DATAWIDTH-1:0] rd_data;
  logic                    commit_wr;
  logic                    wr_ctrl;
  logic                    wr_status;
  logic                    wr_addr_a;
  logic                    wr_addr_b;
  logic                    wr_addr_c;
  logic                    wr_mask;

  // Byte-lane bits of PADDR and the upper PWDATA bits are intentionally dropped.
  logic                    unused_bits;
  assign unused_bits = ^{PADDR[1:0], PWDATA};

  assign setup_idx = PADDR[REG_ADDRWIDTH-1:2];

  // A write commits only on the access edge, using the address latched at setup.
  assign commit_wr = (state == ACCESS) && PSEL && PENABLE && write_lat;
  assign wr_ctrl   = commit_wr && (idx_lat == IDX_CTRL);
  assign wr_status = commit_wr && (idx_lat == IDX_STATUS);
  assign wr_addr_a = commit_wr && (idx_lat == IDX_ADDR_A);
  assign wr_addr_b = commit_wr && (idx_lat == IDX_ADDR_B);
  assign wr_addr_c = commit_wr && (idx_lat == IDX_ADDR_C);
  assign wr_mask   = commit_wr && (idx_lat == IDX_MASK);

  assign PREADY = (state == ACCESS);

`ifdef APB_PSLVERR_EN
  // Error decode uses the setup-phase address and direction, held for the access.
  assign PSLVERR = (state == ACCESS) &&
                   ((idx_lat > IDX_ID) || (write_lat && (idx_lat == IDX_ID)));
`endif

  // Read mux evaluated on the setup-phase address; unused bits and offsets read 0.
  always_comb begin
    rd_data = '0;
    case (setup_idx)
      IDX_CTRL:   rd_data[4:0]            = ctrl_q;
      IDX_STATUS: rd_data[1:0]            = {ctrl_q[0], done_sticky};
      IDX_ADDR_A: rd_data[AWIDTH-1:0]     = addr_a_q;
      IDX_ADDR_B: rd_data[AWIDTH-1:0]     = addr_b_q;
      IDX_ADDR_C: rd_data[AWIDTH-1:0]     = addr_c_q;
      IDX_MASK:   rd_data[MASK_WIDTH-1:0] = mask_q;
      IDX_ID:     rd_data                 = ID_VALUE;
      default:    rd_data                 = '0;
    endcase
  end

  // Transfer FSM: latch setup-phase controls and load PRDATA on a read setup.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      idx_lat   <= '0;
      write_lat <= 1'b0;
      PRDATA    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            state     <= ACCESS;
            idx_lat   <= setup_idx;
            write_lat <= PWRITE;
            if (!PWRITE) begin
              PRDATA <= rd_data;
            end
          end
        end
        ACCESS: begin
          if (!PSEL || PENABLE) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Register file: a CTRL write beats the done-clear; a done set beats the W1C.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ctrl_q      <= '0;
      done_sticky <= 1'b0;
      addr_a_q    <= '0;
      addr_b_q    <= '0;
      addr_c_q    <= '0;
      mask_q      <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl_q <= PWDATA[4:0];
      end else if (done_tpu) begin
        ctrl_q[0] <= 1'b0;
      end

      if (done_tpu) begin
        done_sticky <= 1'b1;
      end else if (wr_status && PWDATA[0]) begin
        done_sticky <= 1'b0;
      end

      if (wr_addr_a) addr_a_q <= PWDATA[AWIDTH-1:0];
      if (wr_addr_b) addr_b_q <= PWDATA[AWIDTH-1:0];
      if (wr_addr_c) addr_c_q <= PWDATA[AWIDTH-1:0];
      if (wr_mask)   mask_q   <= PWDATA[MASK_WIDTH-1:0];
    end
  end

  assign start_tpu         = ctrl_q[0];
  assign enable_matmul     = ctrl_q[1];
  assign enable_norm       = ctrl_q[2];
  assign enable_pool       = ctrl_q[3];
  assign enable_activation = ctrl_q[4];
  assign address_mat_a     = addr_a_q;
  assign address_mat_b     = addr_b_q;
  assign address_mat_c     = addr_c_q;
  assign validity_mask     = mask_q;

endmodule

// File: tb/tb_apb_cfg_responder.sv
// Self-checking bench for apb_cfg_responder: a reference register model feeds
// an expected-read queue that is drained during each access phase.
module tb_apb_cfg_responder;

  localparam int AW  = 8;
  localparam int DW  = 32;
  localparam int AWD = 10;
  localparam int MW  = 8;

  logic          clk = 1'b0;
  logic          resetn;
  logic [AW-1:0] PADDR;
  logic          PWRITE;
  logic          PSEL;
  logic          PENABLE;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA;
  logic          PREADY;
`ifdef APB_PSLVERR_EN
  logic          PSLVERR;
`endif
  logic          done_tpu;
  logic          start_tpu;
  logic          enable_matmul, enable_norm, enable_pool, enable_activation;
  logic [AWD-1:0] address_mat_a, address_mat_b, address_mat_c;
  logic [MW-1:0]  validity_mask;

  always #5 clk = ~clk;

  apb_cfg_responder #(
    .REG_ADDRWIDTH(AW), .REG_DATAWIDTH(DW), .AWIDTH(AWD), .MASK_WIDTH(MW)
  ) dut (
    .clk(clk), .resetn(resetn), .PADDR(PADDR), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
`ifdef APB_PSLVERR_EN
    .PSLVERR(PSLVERR),
`endif
    .done_tpu(done_tpu), .start_tpu(start_tpu), .enable_matmul(enable_matmul),
    .enable_norm(enable_norm), .enable_pool(enable_pool),
    .enable_activation(enable_activation), .address_mat_a(address_mat_a),
    .address_mat_b(address_mat_b), .address_mat_c(address_mat_c),
    .validity_mask(validity_mask)
  );

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  // Reference model of the register file.
  logic [4:0]     m_ctrl;
  logic           m_sticky;
  logic [AWD-1:0] m_a, m_b, m_c;
  logic [MW-1:0]  m_mask;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ctrl = '0; m_sticky = 1'b0; m_a = '0; m_b = '0; m_c = '0; m_mask = '0;
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    r = '0;
    case (int'(a[AW-1:2]))
      0: r[4:0]    = m_ctrl;
      1: r[1:0]    = {m_ctrl[0], m_sticky};
      2: r[AWD-1:0] = m_a;
      3: r[AWD-1:0] = m_b;
      4: r[AWD-1:0] = m_c;
      5: r[MW-1:0]  = m_mask;
      6: r = 32'h5450_5501;
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic model_err(input logic [AW-1:0] a, input logic wr);
    return (int'(a[AW-1:2]) > 6) || (wr && (int'(a[AW-1:2]) == 6));
  endfunction

  // done_tpu on the commit edge: sticky set wins over W1C, CTRL write wins over clear.
  task automatic model_wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic done);
    if (done) begin
      m_sticky  = 1'b1;
      m_ctrl[0] = 1'b0;
    end
    case (int'(a[AW-1:2]))
      0: m_ctrl = d[4:0];
      1: if (d[0] && !done) m_sticky = 1'b0;
      2: m_a = d[AWD-1:0];
      3: m_b = d[AWD-1:0];
      4: m_c = d[AWD-1:0];
      5: m_mask = d[MW-1:0];
      default: ;
    endcase
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_start"}, start_tpu, m_ctrl[0]);
    chk({tag, "_en"}, {enable_activation, enable_pool, enable_norm, enable_matmul}, m_ctrl[4:1]);
    chk({tag, "_addr_a"}, address_mat_a, m_a);
    chk({tag, "_addr_b"}, address_mat_b, m_b);
    chk({tag, "_addr_c"}, address_mat_c, m_c);
    chk({tag, "_mask"}, validity_mask, m_mask);
  endtask

  task automatic apb_write(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic with_done);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = 1'b1; PWDATA = d;
    @(posedge clk); #1;
    PENABLE = 1'b1; done_tpu = with_done;
    chk("wr_pready", PREADY, 1);
`ifdef APB_PSLVERR_EN
    chk("wr_pslverr", PSLVERR, model_err(a, 1'b1));
`endif
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; done_tpu = 1'b0;
    model_wr(a, d, with_done);
  endtask

  task automatic apb_read(input logic [AW-1:0] a, input string tag);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = a; PWRITE = 1'b0;
    exp_q.push_back(model_rd(a));
    @(posedge clk); #1;
    PENABLE = 1'b1;
    chk({tag, "_pready"}, PREADY, 1);
`ifdef APB_PSLVERR_EN
    chk({tag, "_pslverr"}, PSLVERR, model_err(a, 1'b0));
`endif
    if (exp_q.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL %s: no expected entry queued", tag);
    end else begin
      chk(tag, PRDATA, exp_q.pop_front());
    end
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  task automatic pulse_done();
    @(posedge clk); #1; done_tpu = 1'b1;
    @(posedge clk); #1; done_tpu = 1'b0;
    m_ctrl[0] = 1'b0; m_sticky = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PADDR = '0; PWRITE = 1'b0;
    PWDATA = '0; done_tpu = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_pready", PREADY, 0);
    chk("rst_prdata", PRDATA, 0);
    check_outputs("rst");
    resetn = 1'b1;

    // Base addresses and mask, with truncation of oversize write data.
    apb_write(8'h08, 32'h0000_01A5, 1'b0);
    apb_write(8'h0C, 32'hFFFF_FFFF, 1'b0);
    apb_write(8'h10, 32'h0000_0005, 1'b0);
    apb_write(8'h14, 32'h0000_00F0, 1'b0);
    check_outputs("wr1");
    apb_read(8'h08, "rd_addr_a");
    apb_read(8'h0C, "rd_addr_b");
    apb_read(8'h10, "rd_addr_c");
    apb_read(8'h17, "rd_mask_lsb_ignored");

    // Start / done / W1C.
    apb_write(8'h00, 32'h0000_001F, 1'b0);
    check_outputs("ctrl1f");
    apb_read(8'h04, "rd_status_busy");
    pulse_done();
    check_outputs("done");
    apb_read(8'h04, "rd_status_done");
    apb_read(8'h00, "rd_ctrl_after_done");
    apb_write(8'h04, 32'h0000_0001, 1'b0);
    apb_read(8'h04, "rd_status_clr");

    // Same-edge collisions.
    pulse_done();
    apb_write(8'h04, 32'h0000_0001, 1'b1);
    apb_read(8'h04, "rd_status_set_wins");
    apb_write(8'h00, 32'h0000_0001, 1'b1);
    check_outputs("ctrl_wins");

    // ID, ID write ignored, unmapped offset; PRDATA holds across writes.
    apb_read(8'h18, "rd_id");
    apb_write(8'h18, 32'h0000_0000, 1'b0);
    chk("prdata_hold", PRDATA, 32'h5450_5501);
    apb_read(8'h18, "rd_id_again");
    apb_read(8'h3C, "rd_unmapped");
    apb_write(8'h3C, 32'hFFFF_FFFF, 1'b0);
    check_outputs("unmapped_wr");

    // PENABLE without a setup phase is ignored.
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b1; PADDR = 8'h08; PWRITE = 1'b1; PWDATA = 32'h77;
    @(posedge clk); #1;
    chk("noset_pready0", PREADY, 0);
    @(posedge clk); #1;
    chk("noset_pready1", PREADY, 0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge clk); #1;
    chk("noset_addr_a", address_mat_a, m_a);

    // Address change between setup and access: setup address is used.
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h0C; PWRITE = 1'b1; PWDATA = 32'h123;
    @(posedge clk); #1;
    PENABLE = 1'b1; PADDR = 8'h10;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    model_wr(8'h0C, 32'h123, 1'b0);
    check_outputs("latched_addr");

    // Reset during the setup phase of a write.
    apb_write(8'h00, 32'h0000_001F, 1'b0);
    @(posedge clk); #1;
    PSEL = 1'b1; PENABLE = 1'b0; PADDR = 8'h14; PWRITE = 1'b1; PWDATA = 32'hAA;
    resetn = 1'b0;
    @(posedge clk); #1;
    PENABLE = 1'b1;
    @(posedge clk); #1;
    PSEL = 1'b0; PENABLE = 1'b0; resetn = 1'b1;
    model_reset();
    chk("mid_rst_pready", PREADY, 0);
    chk("mid_rst_prdata", PRDATA, 0);
    check_outputs("mid_rst");
    apb_read(8'h14, "rd_mask_after_rst");
    apb_write(8'h08, 32'h0000_002C, 1'b0);
    check_outputs("post_rst_wr");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
